eight_bit_fmultiplier: RTL and testbench

//  Sequential 8-bit floating-point multiplier; upstream stage of EightBitFAdder in each systolic PE.

---
 rtl/eight_bit_fmultiplier.sv | 120 ++++++++++++
 tb/tb_eight_bit_fmultiplier.sv | 138 +++++++++++++
 2 files changed

// File: rtl/eight_bit_fmultiplier.sv
// Sequential 1-3-4 floating-point multiplier (sign, 3-bit exp bias 3, 4-bit frac).
// Shift-add significand product, iterative normalise, truncating pack with ovf/uvf flags.
module eight_bit_fmultiplier (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       busy,
  output logic       prod_valid,
  output logic [7:0] prod,
  output logic       ovf,
  output logic       uvf
);

  localparam int BIAS      = 3;
  localparam int MUL_STEPS = 5;

  typedef enum logic [2:0] {IDLE, MUL, NORM, PACK, DONE} state_t;

  state_t             state;
  logic               sign;
  logic               zero;
  logic [9:0]         mcand;
  logic [4:0]         mplier;
  logic [9:0]         p;
  logic signed [5:0]  e;
  logic [2:0]         cnt;

  logic [2:0] ea_eff, eb_eff;
  logic [4:0] a_sig, b_sig;
  logic       accept;

  // Denormals use exponent 1 with no hidden bit.
  assign ea_eff = (a[6:4] == 3'd0) ? 3'd1 : a[6:4];
  assign eb_eff = (b[6:4] == 3'd0) ? 3'd1 : b[6:4];
  assign a_sig  = {a[6:4] != 3'd0, a[3:0]};
  assign b_sig  = {b[6:4] != 3'd0, b[3:0]};
  assign accept = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      prod_valid <= 1'b0;
      prod       <= 8'h00;
      ovf        <= 1'b0;
      uvf        <= 1'b0;
      sign       <= 1'b0;
      zero       <= 1'b0;
      mcand      <= 10'd0;
      mplier     <= 5'd0;
      p          <= 10'd0;
      e          <= 6'sd0;
      cnt        <= 3'd0;
    end else if (accept) begin
      state      <= MUL;
      busy       <= 1'b1;
      prod_valid <= 1'b0;
      ovf        <= 1'b0;
      uvf        <= 1'b0;
      sign       <= a[7] ^ b[7];
      zero       <= (a[6:0] == 7'd0) || (b[6:0] == 7'd0);
      mcand      <= {5'd0, a_sig};
      mplier     <= b_sig;
      p          <= 10'd0;
      e          <= $signed({3'd0, ea_eff}) + $signed({3'd0, eb_eff}) - 6'(BIAS);
      cnt        <= 3'd0;
    end else begin
      case (state)
        MUL: begin
          if (zero) begin
            state <= PACK;
          end else begin
            if (mplier[0]) p <= p + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 3'd1;
            if (cnt == 3'(MUL_STEPS - 1)) state <= NORM;
          end
        end
        NORM: begin
          // Right shifts truncate, giving round-toward-zero.
          if (p[9]) begin
            p <= p >> 1;
            e <= e + 6'sd1;
          end else if (e < 6'sd1) begin
            p <= p >> 1;
            e <= e + 6'sd1;
          end else if (!p[8] && p != 10'd0 && e > 6'sd1) begin
            p <= p << 1;
            e <= e - 6'sd1;
          end else begin
            state <= PACK;
          end
        end
        PACK: begin
          state      <= DONE;
          busy       <= 1'b0;
          prod_valid <= 1'b1;
          if (zero) begin
            prod <= 8'h00;
          end else if (e > 6'sd7) begin
            prod <= {sign, 7'h7F};
            ovf  <= 1'b1;
          end else if (p[8]) begin
            prod <= {sign, e[2:0], p[7:4]};
          end else if (p[7:4] != 4'd0) begin
            prod <= {sign, 3'b000, p[7:4]};
          end else begin
            prod <= 8'h00;
            uvf  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eight_bit_fmultiplier.sv
// Scoreboard bench: expected {ovf,uvf,prod} queued at issue, popped when prod_valid rises.
module tb_eight_bit_fmultiplier;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic       busy, prod_valid, ovf, uvf;
  logic [7:0] prod;

  int errs = 0, checks = 0;
  logic [9:0] sb[$];

  eight_bit_fmultiplier dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .prod_valid(prod_valid), .prod(prod), .ovf(ovf), .uvf(uvf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference: exact product in units of 2^-6, truncated, then re-encoded.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y);
    int sx, sy, ex, ey, m, sh, q, k, ee, f;
    logic s;
    s = x[7] ^ y[7];
    if (x[6:0] == 0 || y[6:0] == 0) return 10'h000;
    sx = (x[6:4] != 0) ? 16 + x[3:0] : x[3:0];
    sy = (y[6:4] != 0) ? 16 + y[3:0] : y[3:0];
    ex = (x[6:4] == 0) ? 1 : x[6:4];
    ey = (y[6:4] == 0) ? 1 : y[6:4];
    m  = sx * sy;
    sh = ex + ey - 8;
    q  = (sh >= 0) ? (m << sh) : (m >> (-sh));
    if (q == 0) return {2'b01, 8'h00};
    if (q < 16) return {2'b00, s, 3'b000, 4'(q)};
    k = 0;
    for (int i = 0; i < 31; i++) if (q >= (1 << i)) k = i;
    ee = k - 3;
    if (ee > 7) return {2'b10, s, 7'h7F};
    f = (q >> (ee - 1)) - 16;
    return {2'b00, s, 3'(ee), 4'(f)};
  endfunction

  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input int hold, input int exp_lat);
    int lat;
    bit done;
    logic [9:0] exp_v;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    sb.push_back(model(x, y));
    @(posedge clk);
    lat = 0; done = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      if (lat >= hold) start = 1'b0;
      else begin a = 8'($urandom); b = 8'($urandom); end
      if (lat == 0) begin
        chk("accept_pv_low", prod_valid, 0);
        chk("accept_busy", busy, 1);
      end
      if (prod_valid) done = 1;
      else begin @(posedge clk); lat++; end
    end
    start = 1'b0;
    exp_v = sb.pop_front();
    if (!done) chk("timeout", 0, 1);
    else begin
      chk($sformatf("prod %h*%h", x, y), prod, exp_v[7:0]);
      chk($sformatf("ovf %h*%h", x, y), ovf, exp_v[9]);
      chk($sformatf("uvf %h*%h", x, y), uvf, exp_v[8]);
      chk("done_busy", busy, 0);
      if (exp_lat != 0) chk($sformatf("latency %h*%h", x, y), lat, exp_lat);
    end
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_pv", prod_valid, 0);
    chk("rst_prod", prod, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_uvf", uvf, 0);
    @(negedge clk); rst = 1'b0;

    // Directed cases with hand-derived expectations.
    run_op(8'h30, 8'h30, 0, 7);
    chk("dir_30x30", prod, 8'h30);
    run_op(8'hB8, 8'h40, 0, 0);
    chk("dir_B8x40", prod, 8'hC8);
    run_op(8'h10, 8'h10, 0, 0);
    chk("dir_10x10", prod, 8'h04);
    run_op(8'h01, 8'h50, 0, 0);
    chk("dir_01x50", prod, 8'h04);
    run_op(8'hFF, 8'h7F, 0, 0);
    chk("dir_FFx7F", {ovf, prod}, 9'h1FF);
    run_op(8'h01, 8'h01, 0, 0);
    chk("dir_01x01", {uvf, prod}, 9'h100);
    run_op(8'h00, 8'h55, 0, 2);
    run_op(8'h80, 8'hC3, 0, 2);

    // start held while busy with changing operands must not disturb the result.
    run_op(8'hB8, 8'h40, 3, 0);
    chk("hold_B8x40", prod, 8'hC8);

    for (int i = 0; i < 40; i++) run_op(8'($urandom), 8'($urandom), 0, 0);

    // Reset pulse mid-MUL aborts with all outputs cleared.
    run_op(8'hB8, 8'h40, 0, 0);
    @(negedge clk);
    a = 8'h7F; b = 8'h7F; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_pv", prod_valid, 0);
    chk("abort_prod", prod, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_uvf", uvf, 0);
    @(negedge clk); rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("abort_no_pv", prod_valid, 0);
    chk("abort_idle_busy", busy, 0);
    run_op(8'h30, 8'h30, 0, 7);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
